rr_req_arbiter: RTL and testbench

RR_REQ_ARBITER -- requirements
Module: rr_req_arbiter

---
 rtl/arb_pkg.sv | 15 +
 rtl/rr_pick.sv | 35 +++
 rtl/rr_req_arbiter.sv | 136 +++++++++++++
 tb/tb_rr_req_arbiter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared constants and types for the round-robin request arbiter.
// Latency: none (declarations only).
// Backpressure: n/a.
package arb_pkg;

    localparam int N_REQ   = 8;
    localparam int IDX_W   = 3;
    localparam int STATS_W = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

endpackage

// File: rtl/rr_pick.sv
// Masked priority select: first set req bit at or above ptr, wrapping 7 -> 0.
// Latency: combinational.
// Backpressure: none; the caller decides when the pick is loaded.
module rr_pick
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] pick,
    output logic             any
);

    logic [IDX_W-1:0] idx;
    logic             found;

    // Walk the requesters starting at ptr; the 3-bit index wraps naturally.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = ptr + IDX_W'(i);
            if (!found && req[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

    // Any request at all, regardless of pointer position.
    always_comb begin
        any = |req;
    end

endmodule

// File: rtl/rr_req_arbiter.sv
// Round-robin arbiter over 8 level requests with a registered one-hot grant (RR_ARB_STATS_EN adds grant_count).
// Latency: grant_valid rises one cycle after a request; back-to-back grants every cycle on handshake.
// Backpressure: grant is held stable while grant_valid=1 and grant_ready=0; ptr advances only on handshake.
module rr_req_arbiter #(
    parameter int N_REQ = arb_pkg::N_REQ
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic             grant_valid,
    input  logic             grant_ready
`ifdef RR_ARB_STATS_EN
    ,
    output logic [arb_pkg::STATS_W-1:0] grant_count
`endif
);

    import arb_pkg::*;

    // One-hot to index for the pointer update; kept here so ptr does not
    // depend on the downstream encoder.
    function automatic logic [IDX_W-1:0] oh_to_idx(input logic [N_REQ-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (oh[i]) idx = idx | IDX_W'(i);
        end
        return idx;
    endfunction

    state_e           state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             rst_sync_q;

    logic             hs;
    logic [IDX_W-1:0] next_ptr;
    logic [IDX_W-1:0] pick_ptr;
    logic [N_REQ-1:0] pick;
    logic             pick_any;

    // Reset release is taken one clock later so deassertion is synchronous;
    // assertion still clears everything asynchronously through rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= 1'b0;
        else        rst_sync_q <= 1'b1;
    end

    // Handshake and the pointer the selector should use this cycle: on a
    // handshake the freshly advanced pointer, so the next grant is same-cycle.
    always_comb begin
        hs       = (state_q == GRANT) && grant_ready;
        next_ptr = oh_to_idx(grant_q) + IDX_W'(1);
        pick_ptr = hs ? next_ptr : ptr_q;
    end

    rr_pick u_pick (
        .req  (req),
        .ptr  (pick_ptr),
        .pick (pick),
        .any  (pick_any)
    );

    // State register: grant and ptr live with the FSM state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else if (!rst_sync_q) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next-state: load on request from IDLE; in GRANT hold until handshake,
    // then reload from the same-cycle req or fall back to IDLE.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = GRANT;
                    grant_d = pick;
                end
            end
            GRANT: begin
                if (hs) begin
                    ptr_d = next_ptr;
                    if (pick_any) begin
                        grant_d = pick;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Outputs: grant is zero whenever the FSM is idle, so it is driven directly.
    always_comb begin
        grant       = grant_q;
        grant_valid = (state_q == GRANT);
    end

`ifdef RR_ARB_STATS_EN
    logic [STATS_W-1:0] cnt_q;

    // Saturating handshake counter, reset alongside the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (!rst_sync_q) begin
            cnt_q <= '0;
        end else if (hs && (cnt_q != {STATS_W{1'b1}})) begin
            cnt_q <= cnt_q + STATS_W'(1);
        end
    end

    assign grant_count = cnt_q;
`endif

endmodule

// File: tb/tb_rr_req_arbiter.sv
// Directed bench for rr_req_arbiter: vector table plus reset and counter sequences.
// Latency: checks one cycle after each applied input.
// Backpressure: grant_ready driven from the vectors.
module tb_rr_req_arbiter;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] grant;
    logic       grant_valid;
    logic       grant_ready;
`ifdef RR_ARB_STATS_EN
    logic [15:0] grant_count;
`endif

    int n_tests;
    int n_fail;

    rr_req_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_ready (grant_ready)
`ifdef RR_ARB_STATS_EN
        ,
        .grant_count (grant_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic [7:0] req;
        logic       rdy;
        logic [7:0] exp_grant;
        logic       exp_vld;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [7:0] rq, input logic rd,
                       input logic [7:0] g, input logic v);
        vec_t t;
        t.rst = r; t.req = rq; t.rdy = rd; t.exp_grant = g; t.exp_vld = v;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input int step,
                         input logic [7:0] eg, input logic ev);
        n_tests++;
        if (grant !== eg || grant_valid !== ev) begin
            n_fail++;
            $display("FAIL %s step %0d: grant=%h valid=%b, expected grant=%h valid=%b",
                     name, step, grant, grant_valid, eg, ev);
        end
    endtask

    // Pulse reset; inputs idle during it. Release lands 1 time unit after an edge.
    task automatic do_reset();
        req         = 8'h00;
        grant_ready = 1'b0;
        rst_n       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        req         = 8'h00;
        grant_ready = 1'b0;

        // Reset, then idle with and without a stray ready.
        add(1, 8'h00, 0, 8'h00, 0);
        add(0, 8'h00, 0, 8'h00, 0);
        add(0, 8'h00, 0, 8'h00, 0);
        add(0, 8'h00, 0, 8'h00, 0);
        add(0, 8'h00, 1, 8'h00, 0);
        add(0, 8'h00, 1, 8'h00, 0);
        // All requesting: full rotation from ptr 0 and wrap.
        add(0, 8'hFF, 1, 8'h01, 1);
        add(0, 8'hFF, 1, 8'h02, 1);
        add(0, 8'hFF, 1, 8'h04, 1);
        add(0, 8'hFF, 1, 8'h08, 1);
        add(0, 8'hFF, 1, 8'h10, 1);
        add(0, 8'hFF, 1, 8'h20, 1);
        add(0, 8'hFF, 1, 8'h40, 1);
        add(0, 8'hFF, 1, 8'h80, 1);
        add(0, 8'hFF, 1, 8'h01, 1);
        add(0, 8'h00, 1, 8'h00, 0);
        // From reset, two requesters alternate; sync edge first.
        add(1, 8'h21, 1, 8'h00, 0);
        add(0, 8'h21, 1, 8'h01, 1);
        add(0, 8'h21, 1, 8'h20, 1);
        add(0, 8'h21, 1, 8'h01, 1);
        add(0, 8'h00, 1, 8'h00, 0);
        // Hold under backpressure after the request drops.
        add(0, 8'h04, 0, 8'h04, 1);
        add(0, 8'h00, 0, 8'h04, 1);
        add(0, 8'h00, 0, 8'h04, 1);
        add(0, 8'h00, 0, 8'h04, 1);
        add(0, 8'h00, 0, 8'h04, 1);
        add(0, 8'h00, 1, 8'h00, 0);
        // ptr=3: persistent requester drops to lowest priority.
        add(0, 8'h0C, 0, 8'h08, 1);
        add(0, 8'h0C, 1, 8'h04, 1);
        add(0, 8'h0C, 1, 8'h08, 1);
        add(0, 8'h00, 1, 8'h00, 0);
        // ptr=4: grant stable while req changes, then reload from new req.
        add(0, 8'h02, 0, 8'h02, 1);
        add(0, 8'h80, 0, 8'h02, 1);
        add(0, 8'h80, 1, 8'h80, 1);
        add(0, 8'h00, 1, 8'h00, 0);

        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            req         = vecs[i].req;
            grant_ready = vecs[i].rdy;
            @(posedge clk);
            #1;
            check("vec", i, vecs[i].exp_grant, vecs[i].exp_vld);
        end

        // Reset asserted mid-grant clears outputs without waiting for a clock.
        do_reset();
        req         = 8'h10;
        grant_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_rst_grant", 0, 8'h10, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", 0, 8'h00, 1'b0);
        @(posedge clk); #1;
        req   = 8'h11;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_sync", 0, 8'h00, 1'b0);
        @(posedge clk); #1;
        check("post_rst_grant", 0, 8'h01, 1'b1);

`ifdef RR_ARB_STATS_EN
        do_reset();
        n_tests++;
        if (grant_count !== 16'h0000) begin
            n_fail++;
            $display("FAIL cnt_reset: grant_count=%h expected 0000", grant_count);
        end
        req         = 8'hFF;
        grant_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        n_tests++;
        if (grant_count !== 16'd3) begin
            n_fail++;
            $display("FAIL cnt_incr: grant_count=%h expected 0003", grant_count);
        end
        repeat (70000) @(posedge clk);
        #1;
        n_tests++;
        if (grant_count !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL cnt_sat: grant_count=%h expected FFFF", grant_count);
        end
        repeat (10) @(posedge clk);
        #1;
        n_tests++;
        if (grant_count !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL cnt_hold: grant_count=%h expected FFFF", grant_count);
        end
        do_reset();
        n_tests++;
        if (grant_count !== 16'h0000) begin
            n_fail++;
            $display("FAIL cnt_clear: grant_count=%h expected 0000", grant_count);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
